// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply accelerator's APB front-end:
// default geometry shared with the compute engine, register byte offsets,
// CTRL field positions, the scratchpad window base and the APB state enum.
// ---------------------------------------------------------------------------
package matmul_pkg;

    // Geometry defaults, kept identical to the compute engine's.
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int BUS_WIDTH_DEF   = 32;
    localparam int MAX_DIM_DEF     = 4;
    localparam int SP_NTARGETS_DEF = 4;

    // Register byte offsets.
    localparam logic [31:0] OFF_CTRL  = 32'h0000_0000;
    localparam logic [31:0] OFF_OPA   = 32'h0000_0004;
    localparam logic [31:0] OFF_OPB   = 32'h0000_0014;
    localparam logic [31:0] OFF_FLAGS = 32'h0000_0024;
    localparam logic [31:0] SP_BASE   = 32'h0000_0100;

    // CTRL field positions.
    localparam int CTRL_START    = 0;
    localparam int CTRL_BIAS     = 1;
    localparam int CTRL_SPWR_LSB = 2;
    localparam int CTRL_SPRD_LSB = 4;
    localparam int CTRL_N_LSB    = 8;
    localparam int CTRL_K_LSB    = 10;
    localparam int CTRL_M_LSB    = 12;

    // Bits of CTRL that hold state; START is a pulse and is never stored.
    localparam logic [31:0] CTRL_RW_MASK = 32'h0000_3F3E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_SP_WAIT
    } apb_state_e;

endpackage

// File: rtl/matmul_apb_fsm.sv
// ---------------------------------------------------------------------------
// matmul_apb_fsm
// APB protocol sequencer. Tracks IDLE/SETUP/ACCESS/SP_WAIT and produces the
// completion strobes used by the register file.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   psel_i, penable_i    APB control
//   sp_rd_i              current access is a legal scratchpad read
//   err_i                current access must complete with an error
//   pready_o, pslverr_o  APB response (high only in the completion cycle)
//   sp_rd_en_o           one-cycle scratchpad read request (in ACCESS)
//   reg_done_o           register/error access completes this cycle
//   sp_done_o            scratchpad read completes this cycle
// ---------------------------------------------------------------------------
module matmul_apb_fsm
    import matmul_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic psel_i,
    input  logic penable_i,
    input  logic sp_rd_i,
    input  logic err_i,
    output logic pready_o,
    output logic pslverr_o,
    output logic sp_rd_en_o,
    output logic reg_done_o,
    output logic sp_done_o
);

    apb_state_e state_q, state_d;
    logic       next_setup;

    // A new setup phase already on the bus when the current access finishes.
    assign next_setup = psel_i && !penable_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        reg_done_o = 1'b0;
        sp_done_o  = 1'b0;
        sp_rd_en_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (next_setup) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sp_rd_i) begin
                    // Result memory answers one cycle after the request.
                    sp_rd_en_o = 1'b1;
                    state_d    = ST_SP_WAIT;
                end else begin
                    reg_done_o = 1'b1;
                    state_d    = next_setup ? ST_SETUP : ST_IDLE;
                end
            end
            ST_SP_WAIT: begin
                sp_done_o = 1'b1;
                state_d   = next_setup ? ST_SETUP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pready_o  = reg_done_o | sp_done_o;
    assign pslverr_o = reg_done_o & err_i;

endmodule

// File: rtl/matmul_apb_regfile.sv
// ---------------------------------------------------------------------------
// matmul_apb_regfile
// APB slave front-end of the matmul accelerator: CTRL, operand rows A/B,
// latched overflow FLAGS, engine launch/busy tracking and a read window onto
// the engine's result scratchpads.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   psel_i..pstrb_i               APB request
//   prdata_o, pready_o, pslverr_o APB response
//   start_o, busy_o, done_i       engine handshake
//   a_mat_o, b_mat_o              flattened operand rows, row 0 in the LSBs
//   dims_o, bias_o, sp_wr_sel_o   engine configuration from CTRL
//   sp_rd_*                       scratchpad read port
//   flags_i                       per-element overflow flags (latched on done)
// ---------------------------------------------------------------------------
module matmul_apb_regfile
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int MAX_DIM     = MAX_DIM_DEF,
    parameter int ADDR_WIDTH  = 16,
    parameter int SP_NTARGETS = SP_NTARGETS_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              psel_i,
    input  logic                              penable_i,
    input  logic                              pwrite_i,
    input  logic [ADDR_WIDTH-1:0]             paddr_i,
    input  logic [BUS_WIDTH-1:0]              pwdata_i,
    input  logic [BUS_WIDTH/8-1:0]            pstrb_i,
    output logic [BUS_WIDTH-1:0]              prdata_o,
    output logic                              pready_o,
    output logic                              pslverr_o,
    output logic                              start_o,
    output logic                              busy_o,
    input  logic                              done_i,
    output logic [MAX_DIM*BUS_WIDTH-1:0]      a_mat_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]      b_mat_o,
    output logic [5:0]                        dims_o,
    output logic                              bias_o,
    output logic [$clog2(SP_NTARGETS)-1:0]    sp_wr_sel_o,
    output logic [$clog2(SP_NTARGETS)-1:0]    sp_rd_sel_o,
    output logic                              sp_rd_en_o,
    output logic [2*$clog2(MAX_DIM)-1:0]      sp_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]              sp_rd_data_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]        flags_i
);

    localparam int ROW_W     = $clog2(MAX_DIM);
    localparam int SEL_W     = $clog2(SP_NTARGETS);
    localparam int NBYTES    = BUS_WIDTH / 8;
    localparam int ROW_ELEMS = BUS_WIDTH / DATA_WIDTH;
    // K and N index along an operand row, so they are also bounded by how
    // many elements one bus word carries.
    localparam int ROW_LIMIT = (ROW_ELEMS < MAX_DIM) ? ROW_ELEMS : MAX_DIM;

    logic [BUS_WIDTH-1:0]       ctrl_q;
    logic [BUS_WIDTH-1:0]       opa_q [MAX_DIM];
    logic [BUS_WIDTH-1:0]       opb_q [MAX_DIM];
    logic [MAX_DIM*MAX_DIM-1:0] flags_q;
    logic                       start_q, busy_q;

    logic [31:0]          addr_w;
    logic                 aligned, is_ctrl, is_opa, is_opb, is_flags, is_sp;
    logic [ROW_W-1:0]     opa_row, opb_row;
    logic [1:0]           m_f, k_f, n_f;
    logic                 start_req, dim_bad, err, sp_rd;
    logic                 reg_done, sp_done, wr_en;
    logic [BUS_WIDTH-1:0] wmask, rd_data;

    // ---------------- address decode ----------------
    assign addr_w   = 32'(paddr_i);
    assign aligned  = (addr_w[1:0] == 2'b00);
    assign is_ctrl  = aligned && (addr_w == OFF_CTRL);
    assign is_opa   = aligned && (addr_w >= OFF_OPA) && (addr_w < OFF_OPA + 32'(4 * MAX_DIM));
    assign is_opb   = aligned && (addr_w >= OFF_OPB) && (addr_w < OFF_OPB + 32'(4 * MAX_DIM));
    assign is_flags = aligned && (addr_w == OFF_FLAGS);
    assign is_sp    = aligned && (addr_w >= SP_BASE) &&
                      (addr_w < SP_BASE + 32'(4 * MAX_DIM * MAX_DIM));

    // Row bases are row-size aligned modulo MAX_DIM, so a wrapping subtract
    // of the base word index yields the row number.
    assign opa_row = paddr_i[2 +: ROW_W] - ROW_W'(OFF_OPA >> 2);
    assign opb_row = paddr_i[2 +: ROW_W] - ROW_W'(OFF_OPB >> 2);

    // ---------------- error rules ----------------
    assign m_f       = pwdata_i[CTRL_M_LSB +: 2];
    assign k_f       = pwdata_i[CTRL_K_LSB +: 2];
    assign n_f       = pwdata_i[CTRL_N_LSB +: 2];
    assign start_req = pwrite_i && is_ctrl && pwdata_i[CTRL_START];
    assign dim_bad   = start_req && ((32'(m_f) >= 32'(MAX_DIM)) ||
                                     (32'(k_f) >= 32'(ROW_LIMIT)) ||
                                     (32'(n_f) >= 32'(ROW_LIMIT)));

    assign err = !(is_ctrl || is_opa || is_opb || is_flags || is_sp)
              || (pwrite_i && (is_flags || is_sp))
              || (pwrite_i && busy_q && (is_ctrl || is_opa || is_opb))
              || (!pwrite_i && is_sp && busy_q)
              || dim_bad;

    assign sp_rd = is_sp && !pwrite_i && !busy_q;

    matmul_apb_fsm u_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .psel_i     (psel_i),
        .penable_i  (penable_i),
        .sp_rd_i    (sp_rd),
        .err_i      (err),
        .pready_o   (pready_o),
        .pslverr_o  (pslverr_o),
        .sp_rd_en_o (sp_rd_en_o),
        .reg_done_o (reg_done),
        .sp_done_o  (sp_done)
    );

    assign wr_en = reg_done && pwrite_i && !err;

    // Expand byte strobes into a bit mask for the operand rows.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{pstrb_i[gi]}};
    end

    // ---------------- register state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q  <= '0;
            flags_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) begin
                opa_q[r] <= '0;
                opb_q[r] <= '0;
            end
        end else begin
            start_q <= wr_en && start_req;
            if (wr_en && start_req) begin
                busy_q <= 1'b1;
            end else if (done_i && busy_q) begin
                busy_q  <= 1'b0;
            end
            // done_i with the engine idle is a stray pulse and is dropped.
            if (done_i && busy_q) begin
                flags_q <= flags_i;
            end
            if (wr_en && is_ctrl) begin
                ctrl_q <= pwdata_i & BUS_WIDTH'(CTRL_RW_MASK);
            end
            if (wr_en && is_opa) begin
                opa_q[opa_row] <= (pwdata_i & wmask) | (opa_q[opa_row] & ~wmask);
            end
            if (wr_en && is_opb) begin
                opb_q[opb_row] <= (pwdata_i & wmask) | (opb_q[opb_row] & ~wmask);
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
            rd_data = ctrl_q;
        end else if (is_opa) begin
            rd_data = opa_q[opa_row];
        end else if (is_opb) begin
            rd_data = opb_q[opb_row];
        end else if (is_flags) begin
            rd_data = BUS_WIDTH'(flags_q);
        end
    end

    // The result memory's output is already registered; it is forwarded in
    // the SP_WAIT completion cycle when it becomes valid.
    assign prdata_o = (reg_done && !pwrite_i && !err) ? rd_data :
                      (sp_done ? sp_rd_data_i : '0);

    // ---------------- engine side ----------------
    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign dims_o       = {ctrl_q[CTRL_M_LSB +: 2], ctrl_q[CTRL_K_LSB +: 2], ctrl_q[CTRL_N_LSB +: 2]};
    assign bias_o       = ctrl_q[CTRL_BIAS];
    assign sp_wr_sel_o  = ctrl_q[CTRL_SPWR_LSB +: SEL_W];
    assign sp_rd_sel_o  = ctrl_q[CTRL_SPRD_LSB +: SEL_W];
    assign sp_rd_addr_o = paddr_i[2 +: 2*ROW_W];

    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_rows
        assign a_mat_o[gi*BUS_WIDTH +: BUS_WIDTH] = opa_q[gi];
        assign b_mat_o[gi*BUS_WIDTH +: BUS_WIDTH] = opb_q[gi];
    end

endmodule

// File: tb/tb_matmul_apb_regfile.sv
module tb_matmul_apb_regfile;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         psel, penable, pwrite;
    logic [15:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [31:0]  prdata_o;
    logic         pready_o, pslverr_o, start_o, busy_o;
    logic         done_i;
    logic [127:0] a_mat_o, b_mat_o;
    logic [5:0]   dims_o;
    logic         bias_o;
    logic [1:0]   sp_wr_sel_o, sp_rd_sel_o;
    logic         sp_rd_en_o;
    logic [3:0]   sp_rd_addr_o;
    logic [31:0]  sp_rd_data_i;
    logic [15:0]  flags_i;

    int total = 0;
    int bad   = 0;

    // scratchpad model: registered data, valid only the cycle after a request
    logic [31:0] sp_value = 32'h0000_1234;
    bit          sp_seen;
    logic [3:0]  sp_addr_seen;
    logic [1:0]  sp_sel_seen;
    bit          done_in_access = 1'b0;
    logic [15:0] done_flags     = '0;

    always #5 clk = ~clk;

    always @(posedge clk) sp_rd_data_i <= sp_rd_en_o ? sp_value : 32'hDEAD_BEEF;

    matmul_apb_regfile dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pstrb_i      (pstrb),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .start_o      (start_o),
        .busy_o       (busy_o),
        .done_i       (done_i),
        .a_mat_o      (a_mat_o),
        .b_mat_o      (b_mat_o),
        .dims_o       (dims_o),
        .bias_o       (bias_o),
        .sp_wr_sel_o  (sp_wr_sel_o),
        .sp_rd_sel_o  (sp_rd_sel_o),
        .sp_rd_en_o   (sp_rd_en_o),
        .sp_rd_addr_o (sp_rd_addr_o),
        .sp_rd_data_i (sp_rd_data_i),
        .flags_i      (flags_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One APB transfer; entered and left at posedge+1.
    task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output logic err, output int waits);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wr ? data : 32'h0;
        pstrb   = wr ? strb : 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        waits   = 0;
        sp_seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pready_o) break;
            if (sp_rd_en_o) begin
                sp_seen      = 1'b1;
                sp_addr_seen = sp_rd_addr_o;
                sp_sel_seen  = sp_rd_sel_o;
            end
            waits++;
            if (waits > 8) begin
                total++;
                bad++;
                $display("FAIL apb_timeout addr=%h no pready", addr);
                break;
            end
        end
        rdata = prdata_o;
        err   = pslverr_o;
        if (done_in_access) begin
            done_i  = 1'b1;
            flags_i = done_flags;
        end
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        done_i  = 1'b0;
        $display("apb %s addr=%h wdata=%h strb=%h rdata=%h err=%0b waits=%0d",
                 wr ? "WR" : "RD", addr, wr ? data : 32'h0, strb, rdata, err, waits);
    endtask

    task automatic pulse_done(input logic [15:0] f);
        done_i  = 1'b1;
        flags_i = f;
        @(posedge clk); #1;
        done_i  = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    logic [31:0] rd;
    logic        er;
    int          wt;

    initial begin
        vecs[0]  = '{0, 16'h0000, 32'h0,         4'h0, 32'h0,         0};
        vecs[1]  = '{0, 16'h0024, 32'h0,         4'h0, 32'h0,         0};
        vecs[2]  = '{0, 16'h0004, 32'h0,         4'h0, 32'h0,         0};
        vecs[3]  = '{1, 16'h0008, 32'h04030201,  4'h5, 32'h0,         0};
        vecs[4]  = '{0, 16'h0008, 32'h0,         4'h0, 32'h00030001,  0};
        vecs[5]  = '{1, 16'h0018, 32'hAABBCCDD,  4'hF, 32'h0,         0};
        vecs[6]  = '{1, 16'h0018, 32'h11223344,  4'hA, 32'h0,         0};
        vecs[7]  = '{0, 16'h0018, 32'h0,         4'h0, 32'h11BB33DD,  0};
        vecs[8]  = '{1, 16'h0028, 32'hFFFFFFFF,  4'hF, 32'h0,         1};
        vecs[9]  = '{1, 16'h0024, 32'h0000FFFF,  4'hF, 32'h0,         1};
        vecs[10] = '{0, 16'h0028, 32'h0,         4'h0, 32'h0,         1};
        vecs[11] = '{0, 16'h0006, 32'h0,         4'h0, 32'h0,         1};
        vecs[12] = '{1, 16'h0100, 32'h00000001,  4'hF, 32'h0,         1};
        vecs[13] = '{1, 16'h0000, 32'hFFFFFFFE,  4'hF, 32'h0,         0};
        vecs[14] = '{0, 16'h0000, 32'h0,         4'h0, 32'h00003F3E,  0};
        vecs[15] = '{1, 16'h0020, 32'hCAFEF00D,  4'hF, 32'h0,         0};
        vecs[16] = '{0, 16'h0020, 32'h0,         4'h0, 32'hCAFEF00D,  0};
        vecs[17] = '{0, 16'h0008, 32'h0,         4'h0, 32'h00030001,  0};
        vecs[18] = '{0, 16'h0024, 32'h0,         4'h0, 32'h0,         0};

        rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; pstrb = '0; done_i = 0; flags_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prdata", prdata_o, 0);
        chk("rst_pready", pready_o, 0);
        chk("rst_pslverr", pslverr_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sp_rd_en", sp_rd_en_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------- table-driven register accesses ----------
        for (int i = 0; i < NVEC; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, wt);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d_waits", i), wt, 0);
        end
        chk("dims_o", dims_o, 6'h3F);
        chk("bias_o", bias_o, 1);
        chk("sp_wr_sel_o", sp_wr_sel_o, 3);
        chk("sp_rd_sel_o", sp_rd_sel_o, 3);
        chk("a_row1", a_mat_o[63:32], 32'h00030001);
        chk("b_row1", b_mat_o[63:32], 32'h11BB33DD);
        chk("b_row3", b_mat_o[127:96], 32'hCAFEF00D);

        // ---------- scratchpad reads ----------
        apb(1, 16'h0000, 32'h00000020, 4'hF, rd, er, wt);
        apb(0, 16'h0114, 32'h0, 4'h0, rd, er, wt);
        chk("sp_rdata", rd, 32'h1234);
        chk("sp_err", er, 0);
        chk("sp_waits", wt, 1);
        chk("sp_req_seen", sp_seen, 1);
        chk("sp_rd_addr", sp_addr_seen, 4'h5);
        chk("sp_rd_sel", sp_sel_seen, 2'h2);
        sp_value = 32'h0000A5A5;
        apb(0, 16'h013C, 32'h0, 4'h0, rd, er, wt);
        chk("sp_last_rdata", rd, 32'hA5A5);
        chk("sp_last_addr", sp_addr_seen, 4'hF);

        // ---------- engine launch / busy ----------
        apb(1, 16'h0000, 32'h00003F01, 4'hF, rd, er, wt);
        chk("start_err", er, 0);
        chk("start_pulse", start_o, 1);
        chk("start_busy", busy_o, 1);
        @(posedge clk); #1;
        chk("start_clear", start_o, 0);
        chk("busy_held", busy_o, 1);
        apb(1, 16'h0014, 32'h11111111, 4'hF, rd, er, wt);
        chk("busy_opb_wr_err", er, 1);
        apb(1, 16'h0000, 32'h00000000, 4'hF, rd, er, wt);
        chk("busy_ctrl_wr_err", er, 1);
        apb(0, 16'h0000, 32'h0, 4'h0, rd, er, wt);
        chk("busy_ctrl_rd", rd, 32'h3F00);
        chk("busy_ctrl_rd_err", er, 0);
        apb(0, 16'h0100, 32'h0, 4'h0, rd, er, wt);
        chk("busy_sp_err", er, 1);
        chk("busy_sp_waits", wt, 0);
        chk("busy_sp_noreq", sp_seen, 0);
        chk("busy_still", busy_o, 1);
        pulse_done(16'h8001);
        chk("done_busy", busy_o, 0);
        apb(0, 16'h0024, 32'h0, 4'h0, rd, er, wt);
        chk("flags_latched", rd, 32'h8001);
        apb(0, 16'h0014, 32'h0, 4'h0, rd, er, wt);
        chk("opb0_unchanged", rd, 32'h0);
        pulse_done(16'h00FF);
        apb(0, 16'h0024, 32'h0, 4'h0, rd, er, wt);
        chk("idle_done_ignored", rd, 32'h8001);

        // START completing in the same cycle as done_i is rejected
        apb(1, 16'h0000, 32'h00003F01, 4'hF, rd, er, wt);
        @(posedge clk); #1;
        done_in_access = 1'b1;
        done_flags     = 16'h0F0F;
        apb(1, 16'h0000, 32'h00003F01, 4'hF, rd, er, wt);
        done_in_access = 1'b0;
        chk("race_err", er, 1);
        chk("race_no_start", start_o, 0);
        chk("race_busy", busy_o, 0);
        apb(0, 16'h0024, 32'h0, 4'h0, rd, er, wt);
        chk("race_flags", rd, 32'h0F0F);

        // ---------- reset while busy ----------
        apb(1, 16'h0000, 32'h00003F01, 4'hF, rd, er, wt);
        chk("pre_rst_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy_clr", busy_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_done(16'hFFFF);
        chk("rst_done_busy", busy_o, 0);
        apb(0, 16'h0000, 32'h0, 4'h0, rd, er, wt);
        chk("rst_ctrl", rd, 32'h0);
        apb(0, 16'h0024, 32'h0, 4'h0, rd, er, wt);
        chk("rst_flags_after_done", rd, 32'h0);

        // ---------- reset during SP_WAIT ----------
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0104;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("spw_access_pready", pready_o, 0);
        chk("spw_access_req", sp_rd_en_o, 1);
        @(posedge clk); #1;
        chk("spw_wait_pready", pready_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("spw_rst_pready", pready_o, 0);
        chk("spw_rst_prdata", prdata_o, 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb(0, 16'h0004, 32'h0, 4'h0, rd, er, wt);
        chk("post_rst_rd", rd, 32'h0);
        chk("post_rst_err", er, 0);
        chk("post_rst_waits", wt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matmul_apb_regfile.md
# matmul_apb_regfile

APB slave front-end of the matrix-multiply accelerator, placed between the system bus and the matmul compute engine. It decodes bus reads and writes into a control register, operand buffers A and B, and a flags register. It launches the engine and tracks its busy state. It also forwards scratchpad reads to the engine's result memory. The bench's bus stimulus drives this block; every transaction in the instruction file terminates here.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one matrix element
- BUS_WIDTH, 32, APB data width; one write carries BUS_WIDTH/DATA_WIDTH elements (one row)
- MAX_DIM, 4, maximum matrix dimension
- ADDR_WIDTH, 16, APB address width
- SP_NTARGETS, 4, number of result scratchpads

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  ADDR_WIDTH  byte address
- pwdata_i  in  BUS_WIDTH  write data
- pstrb_i  in  BUS_WIDTH/8  byte strobes
- prdata_o  out  BUS_WIDTH  read data
- pready_o, pslverr_o  out  1 each  APB response
- start_o  out  1  one-cycle engine launch pulse
- busy_o  out  1  engine running
- done_i  in  1  one-cycle engine completion pulse
- a_mat_o, b_mat_o  out  MAX_DIM*BUS_WIDTH  flattened operand rows; row 0 is in the LSBs
- dims_o  out  6  {M-1, K-1, N-1}, 2 bits each
- bias_o  out  1  accumulate onto the existing scratchpad
- sp_wr_sel_o, sp_rd_sel_o  out  2 each  result target and read source
- sp_rd_en_o  out  1  scratchpad read request
- sp_rd_addr_o  out  4  element index {i,j}
- sp_rd_data_i  in  BUS_WIDTH  element, valid one cycle after sp_rd_en_o
- flags_i  in  MAX_DIM*MAX_DIM  per-element overflow flags, latched on done_i

## Operation
Register map (byte offsets; all other addresses are unmapped):
- 0x00 CTRL, R/W:
  - bit0 START, write-1, self-clearing, reads 0
  - bit1 BIAS
  - [3:2] SP write target, [5:4] SP read source
  - [9:8] N-1, [11:10] K-1, [13:12] M-1
- 0x04..0x10 OPA row 0..3, and 0x14..0x20 OPB row 0..3, R/W; pstrb_i masks bytes
- 0x24 FLAGS, RO; the latched flags_i
- 0x100..0x13C SP window, RO; element (i,j) = paddr_i[5:2], from source CTRL[5:4]

APB FSM states are IDLE, SETUP, ACCESS and SP_WAIT:
- IDLE→SETUP on psel_i && !penable_i.
- SETUP→ACCESS on the next cycle.
- ACCESS of an SP read enters SP_WAIT and asserts sp_rd_en_o for one cycle; SP_WAIT completes on the following cycle.
- All other accesses complete in ACCESS and return to IDLE, or to SETUP if psel_i stays high with penable_i low.

Error rules (the access completes with pslverr_o=1 and has no side effect):
- Unmapped address.
- Write to a RO register.
- Write to OPA, OPB or CTRL while busy_o=1. CTRL reads stay legal while busy.
- Any SP read while busy_o=1.
- START with any dimension field exceeding MAX_DIM-1. This cannot occur for MAX_DIM=4, but implement the check for the parameter.

Engine handshake:
- A legal CTRL write with START=1 produces start_o one cycle after the completing ACCESS edge. busy_o rises in the same cycle.
- done_i clears busy_o on the next edge and latches flags_i into FLAGS.
- done_i while busy_o=0 is ignored.
- A START write completing in the same cycle as done_i sees busy_o=1 and is rejected.

## Timing
- Reset values: prdata_o=0, pready_o=0, pslverr_o=0, start_o=0, busy_o=0, sp_rd_en_o=0. CTRL, OPA, OPB and FLAGS reset to 0.
- Register accesses have zero wait states: pready_o=1 in the first ACCESS cycle.
- SP reads have one wait state: pready_o=0 in ACCESS and 1 in SP_WAIT. prdata_o equals sp_rd_data_i registered.
- prdata_o is 0 on writes and on error completions.
- pready_o and pslverr_o are high only in the completion cycle.
- An async reset mid-transfer or mid-computation returns the FSM to IDLE and clears busy_o. A done_i arriving later is ignored.

## Structure
- Package matmul_pkg holds:
  - the register offsets and CTRL field positions
  - the SP window base
  - the APB state enum
  - the DATA_WIDTH/BUS_WIDTH/MAX_DIM defaults shared with the engine
- One sub-module, matmul_apb_fsm, holds the protocol FSM and produces the completion, error and wait controls. The register file and decode stay in the top.

## Test plan
- Reset, then read CTRL, FLAGS and OPA row 0 → all 0, pslverr_o=0, zero wait states.
- Write OPA row 1 = 0x04030201 with pstrb=0b0101, then read it back → 0x00030001.
- Write CTRL=0x3F01 (START, N=K=M=4) → start_o pulses one cycle after ACCESS, busy_o=1. A write to OPB row 0 is then rejected with pslverr_o=1 and OPB is unchanged. Drive done_i with flags_i=0x8001 → busy_o=0 on the next edge, FLAGS reads 0x8001.
- Read SP at 0x114 with source 2 and sp_rd_data_i=0x1234 → sp_rd_addr_o=5, sp_rd_sel_o=2, pready_o low for one cycle, prdata_o=0x1234.
- Write to 0x28, then write to FLAGS → pslverr_o=1 on both, all registers unchanged.
- Assert rst_ni low while busy_o=1 and during an SP_WAIT → busy_o=0, FSM in IDLE, and a following done_i has no effect.
